// File: rtl/cpld_busctl.sv
// cpld_busctl -- Z80 bus-cycle front end for the 1MB RAM expansion CPLD.
//
// Follows CPU memory cycles with a small registered state machine and
// deglitches I/O writes to the gate array (A15 low) before capturing
// RAM-config (data[7:6]=11) and ROM-config (data[7:6]=10) writes. Every
// output is a register.
//
// Ports:
//   clk        CPU clock; all state changes on the rising edge
//   reset_b    active-low reset, sampled synchronously
//   mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b   Z80 control strobes
//   adr15, adr8, data[7:0]                     CPU address bits and data bus
//   dip[3:0]   dip[0]=shadow enable, dip[3:2]=RAM size (00 off, 01 64K, 10 512K, 11 1MB)
//   ramblock   registered bank/config word
//   mode3      last RAM config selected mode 3 (data[2:0]=011)
//   urom_dis, lrom_dis   upper/lower ROM disables
//   cfg_strobe one-clock pulse alongside each ramblock/mode3 update
//   mwr_cyc, mrd_cyc     memory write / read cycle in progress
//   cyc_state  memory cycle phase: 00 IDLE, 01 T1, 10 T2, 11 END
module cpld_busctl #(
  parameter logic [3:0] SHADOW_BANK = 4'b0111,
  parameter int         DEGLITCH    = 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       mreq_b,
  input  logic       iorq_b,
  input  logic       rd_b,
  input  logic       wr_b,
  input  logic       rfsh_b,
  input  logic       m1_b,
  input  logic       adr15,
  input  logic       adr8,
  input  logic [7:0] data,
  input  logic [3:0] dip,
  output logic [6:0] ramblock,
  output logic       mode3,
  output logic       urom_dis,
  output logic       lrom_dis,
  output logic       cfg_strobe,
  output logic       mwr_cyc,
  output logic       mrd_cyc,
  output logic [1:0] cyc_state
);

  localparam logic [1:0] CYC_IDLE = 2'b00;
  localparam logic [1:0] CYC_T1   = 2'b01;
  localparam logic [1:0] CYC_T2   = 2'b10;
  localparam logic [1:0] CYC_END  = 2'b11;

  localparam logic [0:0] IO_IDLE = 1'b0;
  localparam logic [0:0] IO_HOLD = 1'b1;

  localparam logic [1:0] DEGLITCH_CNT = 2'(DEGLITCH);

  logic [0:0] io_state_q, io_state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic [6:0] ramblock_q, ramblock_d;
  logic       mode3_q, mode3_d;
  logic       urom_q, urom_d;
  logic       lrom_q, lrom_d;
  logic       strobe_q, strobe_d;
  logic [1:0] cyc_q, cyc_d;
  logic       mwr_q, mwr_d;
  logic       mrd_q, mrd_d;

  logic io_qual_s;
  logic capture_s;
  logic mem_blocked_s;
  logic mem_req_s;
  logic unused_s;

  // dip[1] has no function in this block.
  assign unused_s = dip[1];

  // Gate-array write: IORQ+WR with M1 high (not an interrupt acknowledge) and A15 low.
  assign io_qual_s = ~iorq_b & ~wr_b & m1_b & ~adr15;

  // I/O write deglitch and single-capture-per-IORQ sequencing.
  always_comb begin
    io_state_d = io_state_q;
    cnt_d      = cnt_q;
    capture_s  = 1'b0;
    // After reset nothing is captured until IORQ has been seen high, so a
    // reset released in the middle of an OUT cannot latch a partial write.
    armed_d    = armed_q | iorq_b;
    case (io_state_q)
      IO_IDLE: begin
        if (io_qual_s && armed_q) begin
          if ((cnt_q + 2'd1) == DEGLITCH_CNT) begin
            capture_s  = 1'b1;
            io_state_d = IO_HOLD;
            cnt_d      = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          cnt_d = 2'd0;
        end
      end
      IO_HOLD: begin
        if (iorq_b) begin
          io_state_d = IO_IDLE;
          cnt_d      = 2'd0;
        end else begin
          io_state_d = IO_HOLD;
        end
      end
      default: begin
        io_state_d = IO_IDLE;
        cnt_d      = 2'd0;
      end
    endcase
  end

  // Decode a captured write into RAM-config or ROM-config state.
  always_comb begin
    ramblock_d = ramblock_q;
    mode3_d    = mode3_q;
    urom_d     = urom_q;
    lrom_d     = lrom_q;
    strobe_d   = 1'b0;
    if (capture_s) begin
      case (data[7:6])
        2'b11: begin
          case (dip[3:2])
            2'b01: begin
              ramblock_d = {4'b1000, data[2:0]};
              mode3_d    = (data[2:0] == 3'b011);
              strobe_d   = 1'b1;
            end
            2'b10: begin
              ramblock_d = {1'b1, data[5:0]};
              mode3_d    = (data[2:0] == 3'b011);
              strobe_d   = 1'b1;
            end
            2'b11: begin
              // In 1MB shadow mode the reserved shadow bank aliases onto
              // its even partner by clearing bank bit 0 (data[3]).
              if (dip[0] && ({adr8, data[5:3]} == SHADOW_BANK)) begin
                ramblock_d = {adr8, data[5:4], 1'b0, data[2:0]};
              end else begin
                ramblock_d = {adr8, data[5:0]};
              end
              mode3_d  = (data[2:0] == 3'b011);
              strobe_d = 1'b1;
            end
            default: begin
              // Expansion disabled: RAM config writes are ignored.
              ramblock_d = ramblock_q;
            end
          endcase
        end
        2'b10: begin
          urom_d = data[3];
          lrom_d = data[2];
        end
        default: begin
          ramblock_d = ramblock_q;
        end
      endcase
    end else begin
      strobe_d = 1'b0;
    end
  end

  // Refresh and any IORQ activity take the memory tracker out of play.
  assign mem_blocked_s = ~rfsh_b | ~iorq_b;
  assign mem_req_s     = ~mreq_b;

  // Memory cycle phase tracking and read/write flags.
  always_comb begin
    cyc_d = CYC_IDLE;
    mwr_d = 1'b0;
    mrd_d = 1'b0;
    if (mem_blocked_s) begin
      cyc_d = CYC_IDLE;
    end else begin
      case (cyc_q)
        CYC_IDLE: cyc_d = mem_req_s ? CYC_T1 : CYC_IDLE;
        CYC_T1:   cyc_d = mem_req_s ? CYC_T2 : CYC_IDLE;
        CYC_T2:   cyc_d = mem_req_s ? CYC_T2 : CYC_END;
        CYC_END:  cyc_d = mem_req_s ? CYC_T1 : CYC_IDLE;
        default:  cyc_d = CYC_IDLE;
      endcase
    end
    // Flags follow the phase being entered; a low RD always wins over write.
    case (cyc_d)
      CYC_T1: begin
        mrd_d = ~rd_b;
        mwr_d = rd_b;
      end
      CYC_T2: begin
        mrd_d = mrd_q | ~rd_b;
        mwr_d = mwr_q & rd_b & ~mrd_q;
      end
      default: begin
        mrd_d = 1'b0;
        mwr_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      io_state_q <= IO_IDLE;
      cnt_q      <= 2'd0;
      armed_q    <= 1'b0;
      ramblock_q <= 7'd0;
      mode3_q    <= 1'b0;
      urom_q     <= 1'b0;
      lrom_q     <= 1'b0;
      strobe_q   <= 1'b0;
      cyc_q      <= CYC_IDLE;
      mwr_q      <= 1'b0;
      mrd_q      <= 1'b0;
    end else begin
      io_state_q <= io_state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      ramblock_q <= ramblock_d;
      mode3_q    <= mode3_d;
      urom_q     <= urom_d;
      lrom_q     <= lrom_d;
      strobe_q   <= strobe_d;
      cyc_q      <= cyc_d;
      mwr_q      <= mwr_d;
      mrd_q      <= mrd_d;
    end
  end

  assign ramblock   = ramblock_q;
  assign mode3      = mode3_q;
  assign urom_dis   = urom_q;
  assign lrom_dis   = lrom_q;
  assign cfg_strobe = strobe_q;
  assign mwr_cyc    = mwr_q;
  assign mrd_cyc    = mrd_q;
  assign cyc_state  = cyc_q;

endmodule

// File: tb/tb_cpld_busctl.sv
// Self-checking bench for cpld_busctl: a behavioural model is compared with
// the DUT on every falling edge, and directed scenarios add literal checks.
module tb_cpld_busctl;

  localparam int DEG = 2;

  logic       clk = 1'b0;
  logic       reset_b, mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, adr15, adr8;
  logic [7:0] data;
  logic [3:0] dip;
  logic [6:0] ramblock;
  logic       mode3, urom_dis, lrom_dis, cfg_strobe, mwr_cyc, mrd_cyc;
  logic [1:0] cyc_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpld_busctl #(.SHADOW_BANK(4'b0111), .DEGLITCH(DEG)) dut (
    .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .iorq_b(iorq_b),
    .rd_b(rd_b), .wr_b(wr_b), .rfsh_b(rfsh_b), .m1_b(m1_b),
    .adr15(adr15), .adr8(adr8), .data(data), .dip(dip),
    .ramblock(ramblock), .mode3(mode3), .urom_dis(urom_dis),
    .lrom_dis(lrom_dis), .cfg_strobe(cfg_strobe), .mwr_cyc(mwr_cyc),
    .mrd_cyc(mrd_cyc), .cyc_state(cyc_state)
  );

  // ---------------- behavioural model ----------------
  logic [6:0] m_ramblock = 7'd0;
  logic       m_mode3 = 1'b0, m_urom = 1'b0, m_lrom = 1'b0, m_strobe = 1'b0;
  logic       m_mwr = 1'b0, m_mrd = 1'b0;
  int         m_phase = 0;   // 0 idle, 1 T1, 2 T2, 3 END
  int         m_run = 0;     // consecutive qualifying write edges
  bit         m_done = 1'b0; // already captured during this IORQ
  bit         m_armed = 1'b0;
  bit         m_q;
  int         bank;

  always @(posedge clk) begin
    if (!reset_b) begin
      m_ramblock = 7'd0; m_mode3 = 1'b0; m_urom = 1'b0; m_lrom = 1'b0;
      m_strobe = 1'b0; m_mwr = 1'b0; m_mrd = 1'b0; m_phase = 0;
      m_run = 0; m_done = 1'b0; m_armed = 1'b0;
    end else begin
      m_q = !iorq_b && !wr_b && m1_b && !adr15;
      m_strobe = 1'b0;
      if (iorq_b) begin
        m_done = 1'b0; m_armed = 1'b1; m_run = 0;
      end else if (m_q && m_armed && !m_done) begin
        m_run = m_run + 1;
        if (m_run == DEG) begin
          m_done = 1'b1;
          m_run  = 0;
          if (data[7:6] == 2'b11 && dip[3:2] != 2'b00) begin
            bank = int'(adr8) * 8 + int'(data[5:3]);
            if (dip[3:2] == 2'b01)
              m_ramblock = 7'(64 + int'(data[2:0]));
            else if (dip[3:2] == 2'b10)
              m_ramblock = 7'(64 + int'(data[5:0]));
            else if (dip[0] && bank == 7)
              m_ramblock = 7'(int'(adr8) * 64 + int'(data[5:4]) * 16 + int'(data[2:0]));
            else
              m_ramblock = 7'(int'(adr8) * 64 + int'(data[5:0]));
            m_mode3  = (data[2:0] == 3'd3);
            m_strobe = 1'b1;
          end else if (data[7:6] == 2'b10) begin
            m_urom = data[3];
            m_lrom = data[2];
          end
        end
      end else if (!m_done) begin
        m_run = 0;
      end

      if (!rfsh_b || !iorq_b) begin
        m_phase = 0; m_mwr = 1'b0; m_mrd = 1'b0;
      end else begin
        if (m_phase == 0)      m_phase = !mreq_b ? 1 : 0;
        else if (m_phase == 1) m_phase = !mreq_b ? 2 : 0;
        else if (m_phase == 2) m_phase = !mreq_b ? 2 : 3;
        else                   m_phase = !mreq_b ? 1 : 0;
        if (m_phase == 1) begin
          m_mwr = rd_b; m_mrd = !rd_b;
        end else if (m_phase == 2) begin
          if (!rd_b) begin m_mrd = 1'b1; m_mwr = 1'b0; end
        end else begin
          m_mwr = 1'b0; m_mrd = 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("ramblock", {1'b0, ramblock}, {1'b0, m_ramblock});
    check("mode3", {7'd0, mode3}, {7'd0, m_mode3});
    check("urom_dis", {7'd0, urom_dis}, {7'd0, m_urom});
    check("lrom_dis", {7'd0, lrom_dis}, {7'd0, m_lrom});
    check("cfg_strobe", {7'd0, cfg_strobe}, {7'd0, m_strobe});
    check("mwr_cyc", {7'd0, mwr_cyc}, {7'd0, m_mwr});
    check("mrd_cyc", {7'd0, mrd_cyc}, {7'd0, m_mrd});
    check("cyc_state", {6'd0, cyc_state}, 8'(m_phase));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
    rfsh_b = 1'b1; m1_b = 1'b1; adr15 = 1'b1; adr8 = 1'b0; data = 8'h00;
  endtask

  // One OUT to &7Fxx held for DEG+1 edges, then IORQ released.
  task automatic io_case(input string nm, input logic [3:0] d, input logic a8,
                         input logic [7:0] dat, input logic [6:0] e_rb,
                         input logic e_m3, input logic e_s,
                         input logic e_u, input logic e_l);
    dip = d; adr8 = a8; data = dat; adr15 = 1'b0;
    iorq_b = 1'b0; wr_b = 1'b0; m1_b = 1'b1;
    step(DEG - 1);
    check({nm, "_pre_strobe"}, {7'd0, cfg_strobe}, 8'd0);
    step(1);
    check({nm, "_rb"}, {1'b0, ramblock}, {1'b0, e_rb});
    check({nm, "_m3"}, {7'd0, mode3}, {7'd0, e_m3});
    check({nm, "_strobe"}, {7'd0, cfg_strobe}, {7'd0, e_s});
    check({nm, "_rom"}, {6'd0, urom_dis, lrom_dis}, {6'd0, e_u, e_l});
    data = 8'hC0;  // changing data mid-hold must not cause a second capture
    step(1);
    check({nm, "_strobe_off"}, {7'd0, cfg_strobe}, 8'd0);
    check({nm, "_rb_hold"}, {1'b0, ramblock}, {1'b0, e_rb});
    bus_idle();
    step(1);
  endtask

  initial begin
    dip = 4'b0000;
    bus_idle();
    reset_b = 1'b0;
    // Reset with a random bus.
    for (int i = 0; i < 3; i++) begin
      {mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, adr15, adr8} = 8'($urandom);
      data = 8'($urandom);
      dip  = 4'($urandom);
      step(1);
    end
    check("rst_ramblock", {1'b0, ramblock}, 8'd0);
    check("rst_cyc", {6'd0, cyc_state}, 8'd0);
    check("rst_flags", {2'd0, mode3, urom_dis, lrom_dis, cfg_strobe, mwr_cyc, mrd_cyc}, 8'd0);
    bus_idle();
    reset_b = 1'b1;
    step(2);
    check("post_rst_ramblock", {1'b0, ramblock}, 8'd0);

    // RAM/ROM config captures.
    io_case("shadow_alias", 4'b1101, 1'b0, 8'hFB, 7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0);
    // Deglitch: one qualifying edge only.
    dip = 4'b1100; adr8 = 1'b1; data = 8'hC5; adr15 = 1'b0; iorq_b = 1'b0; wr_b = 1'b0;
    step(1);
    bus_idle();
    step(1);
    check("deglitch_rb", {1'b0, ramblock}, 8'h33);
    check("deglitch_strobe", {7'd0, cfg_strobe}, 8'd0);
    io_case("1mb_plain", 4'b1100, 1'b1, 8'hC5, 7'h45, 1'b0, 1'b1, 1'b0, 1'b0);
    io_case("1mb_shadow_miss", 4'b1101, 1'b1, 8'hF9, 7'h79, 1'b0, 1'b1, 1'b0, 1'b0);
    io_case("512k", 4'b1000, 1'b0, 8'hCB, 7'h4B, 1'b1, 1'b1, 1'b0, 1'b0);
    io_case("64k", 4'b0100, 1'b1, 8'hFA, 7'h42, 1'b0, 1'b1, 1'b0, 1'b0);
    io_case("disabled", 4'b0000, 1'b0, 8'hC3, 7'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    io_case("rom_8c", 4'b1100, 1'b0, 8'h8C, 7'h42, 1'b0, 1'b0, 1'b1, 1'b1);
    io_case("rom_84", 4'b1100, 1'b0, 8'h84, 7'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    io_case("ignored_40", 4'b1100, 1'b0, 8'h40, 7'h42, 1'b0, 1'b0, 1'b0, 1'b1);
    io_case("shadow_f8", 4'b1101, 1'b0, 8'hF8, 7'h30, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of an OUT: no capture until IORQ goes high.
    dip = 4'b1100; adr8 = 1'b0; data = 8'hC5; adr15 = 1'b0; iorq_b = 1'b0; wr_b = 1'b0;
    step(1);
    reset_b = 1'b0;
    step(1);
    reset_b = 1'b1;
    step(3);
    check("midrst_rb", {1'b0, ramblock}, 8'd0);
    check("midrst_strobe", {7'd0, cfg_strobe}, 8'd0);
    bus_idle();
    step(1);

    // Memory write cycle, then back-to-back request from END.
    mreq_b = 1'b0; rd_b = 1'b1;
    step(1);
    check("mw_t1", {6'd0, cyc_state}, 8'd1);
    check("mw_t1_flag", {6'd0, mwr_cyc, mrd_cyc}, 8'd2);
    step(1);
    check("mw_t2a", {6'd0, cyc_state}, 8'd2);
    step(1);
    check("mw_t2b", {6'd0, cyc_state, mwr_cyc}, 8'd5);
    mreq_b = 1'b1;
    step(1);
    check("mw_end", {6'd0, cyc_state}, 8'd3);
    check("mw_end_flag", {6'd0, mwr_cyc, mrd_cyc}, 8'd0);
    mreq_b = 1'b0;
    step(1);
    check("b2b_t1", {6'd0, cyc_state}, 8'd1);
    mreq_b = 1'b1;
    step(1);
    check("t1_abort", {6'd0, cyc_state}, 8'd0);

    // Memory read cycle.
    mreq_b = 1'b0; rd_b = 1'b0;
    step(1);
    check("mr_t1_flag", {6'd0, mwr_cyc, mrd_cyc}, 8'd1);
    step(1);
    mreq_b = 1'b1; rd_b = 1'b1;
    step(1);
    check("mr_end", {4'd0, cyc_state, mwr_cyc, mrd_cyc}, 8'hC);
    step(1);

    // RD falling during T2 turns the cycle into a read.
    mreq_b = 1'b0; rd_b = 1'b1;
    step(1);
    rd_b = 1'b0;
    step(1);
    check("rd_wins", {4'd0, cyc_state, mwr_cyc, mrd_cyc}, 8'h9);
    bus_idle();
    step(2);

    // Refresh forces IDLE.
    mreq_b = 1'b0; rd_b = 1'b1;
    step(1);
    rfsh_b = 1'b0;
    step(1);
    check("rfsh", {4'd0, cyc_state, mwr_cyc, mrd_cyc}, 8'd0);
    bus_idle();
    step(1);

    // Interrupt acknowledge (M1 low) never captures.
    dip = 4'b1100; adr15 = 1'b0; data = 8'hFF; iorq_b = 1'b0; m1_b = 1'b0; wr_b = 1'b0;
    step(3);
    check("m1_excl_rb", {1'b0, ramblock}, 8'd0);
    check("m1_excl_strobe", {7'd0, cfg_strobe}, 8'd0);
    bus_idle();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
